draw_text_box: RTL

DRAW_TEXT_BOX -- requirements
Module: draw_text_box

---
 rtl/draw_text_box.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/draw_text_box.sv
// Character text box overlay: composites COLS x ROWS glyphs from an external font ROM onto a video stream.
// Optional 1-pixel outline around the box: define DRAW_TEXT_BOX_BORDER_EN.
module draw_text_box #(
    parameter int          XPOS         = 490,
    parameter int          YPOS         = 600,
    parameter int          COLS         = 5,
    parameter int          ROWS         = 1,
    parameter logic [11:0] FG_COLOR     = 12'h333,
    parameter logic [11:0] BG_COLOR     = 12'heee,
    parameter int          ROM_LAT      = 2,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [1:0]  mode,
    input  logic [7:0]  char_pixels,
    output logic [7:0]  char_xy,
    output logic [3:0]  char_line,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam logic [10:0] X_LO       = 11'(XPOS);
    localparam logic [10:0] X_HI       = 11'(XPOS + 8 * COLS);
    localparam logic [10:0] Y_LO       = 11'(YPOS);
    localparam logic [10:0] Y_HI       = 11'(YPOS + 16 * ROWS);
    localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

    localparam logic [2:0] S_OFF       = 3'd0;
    localparam logic [2:0] S_SHOW      = 3'd1;
    localparam logic [2:0] S_INVERSE   = 3'd2;
    localparam logic [2:0] S_BLINK_ON  = 3'd3;
    localparam logic [2:0] S_BLINK_OFF = 3'd4;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        hblnk;
        logic        vsync;
        logic        vblnk;
        logic [11:0] rgb;
        logic        in_box;
        logic [2:0]  idx;
        logic        on_border;
    } stage_t;

    // Box-relative offsets; widths cover the largest legal box (128 x 256 px).
    logic [6:0] w_hrel;
    logic [7:0] w_vrel;
    logic       w_in_box;
    logic       w_border;

    assign w_hrel    = 7'(hcount_in - X_LO);
    assign w_vrel    = 8'(vcount_in - Y_LO);
    assign char_xy   = {w_vrel[7:4], w_hrel[6:3]};
    assign char_line = w_vrel[3:0];
    assign w_in_box  = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
                       (vcount_in >= Y_LO) && (vcount_in < Y_HI);

`ifdef DRAW_TEXT_BOX_BORDER_EN
    assign w_border = (w_hrel == 7'd0) || (w_hrel == 7'(8 * COLS - 1)) ||
                      (w_vrel == 8'd0) || (w_vrel == 8'(16 * ROWS - 1));
`else
    assign w_border = 1'b0;
`endif

    stage_t w_cur;
    stage_t w_last;

    assign w_cur = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in, hblnk: hblnk_in,
                     vsync: vsync_in, vblnk: vblnk_in, rgb: rgb_in, in_box: w_in_box,
                     idx: w_hrel[2:0], on_border: w_border};

    // Pixel context waits here while the font ROM fetches the matching glyph row.
    if (ROM_LAT == 0) begin : g_no_pipe
        assign w_last = w_cur;
    end else begin : g_pipe
        stage_t r_pipe [ROM_LAT];

        // NOTE: the delay line is reset (unlike a RAM) so every output reads zero while rst is high.
        always_ff @(posedge pclk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < ROM_LAT; k++) r_pipe[k] <= '0;
            end else begin
                // NOTE: non-blocking so each stage takes the previous stage's old value.
                r_pipe[0] <= w_cur;
                for (int k = 1; k < ROM_LAT; k++) r_pipe[k] <= r_pipe[k-1];
            end
        end

        assign w_last = r_pipe[ROM_LAT-1];
    end

    logic [2:0] r_state;
    logic [7:0] r_frame_cnt;
    logic       r_vsync_prev;
    logic       w_frame_start;
    logic       w_blinking;

    assign w_frame_start = vsync_in & ~r_vsync_prev;
    assign w_blinking    = (r_state == S_BLINK_ON) || (r_state == S_BLINK_OFF);

    // Display state only moves at frame start so a mode change never tears the picture.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_state      <= S_OFF;
            r_frame_cnt  <= '0;
            r_vsync_prev <= 1'b0;
        end else begin
            r_vsync_prev <= vsync_in;
            if (w_frame_start) begin
                case (mode)
                    2'b00: begin
                        r_state     <= S_OFF;
                        r_frame_cnt <= '0;
                    end
                    2'b01: begin
                        r_state     <= S_SHOW;
                        r_frame_cnt <= '0;
                    end
                    2'b11: begin
                        r_state     <= S_INVERSE;
                        r_frame_cnt <= '0;
                    end
                    default: begin
                        if (!w_blinking) begin
                            r_state     <= S_BLINK_ON;
                            r_frame_cnt <= '0;
                        end else if (r_frame_cnt == BLINK_LAST) begin
                            r_frame_cnt <= '0;
                            r_state     <= (r_state == S_BLINK_ON) ? S_BLINK_OFF : S_BLINK_ON;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                        end
                    end
                endcase
            end
        end
    end

    logic        w_lit;
    logic [11:0] w_rgb;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_lit = char_pixels[3'd7 - w_last.idx] | w_last.on_border;
        w_rgb = w_last.rgb;
        if (w_last.in_box) begin
            case (r_state)
                S_SHOW, S_BLINK_ON: w_rgb = w_lit ? FG_COLOR : BG_COLOR;
                S_INVERSE:          w_rgb = w_lit ? BG_COLOR : FG_COLOR;
                default:            w_rgb = w_last.rgb;
            endcase
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= w_last.hcount;
            vcount_out <= w_last.vcount;
            hsync_out  <= w_last.hsync;
            hblnk_out  <= w_last.hblnk;
            vsync_out  <= w_last.vsync;
            vblnk_out  <= w_last.vblnk;
            rgb_out    <= w_rgb;
        end
    end

endmodule
